sdr_qsram_ctrl: RTL and testbench
=================================

Name: sdr_qsram_ctrl

Overview:
- Parametrised next-generation synchronous SDR quad-bank SRAM block with an internal storage array, a pipelined read path and a built-in refresh scheduler.
- Replaces the fixed-width bidirectional-bus memory block: split write/read data buses, a ready/valid handshake, configurable read latency and periodic or on-demand refresh sweeps across all banks.
- Sits between the board-level clock/supply blocks and any client logic needing local buffered storage.

Parameters:
- ADDR_WIDTH, 10, word address width; array depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 9, data word width.
- BANK_BITS, 2, number of address MSBs selecting the bank; NUM_BANKS = 2**BANK_BITS.
- READ_LATENCY, 2, cycles from accepted read to ReadValid; legal range 1..4.
- REFRESH_INTERVAL, 64, Clock cycles between automatic refresh sweeps; must be >= 8.
- REFRESH_CYCLES, 4, cycles spent refreshing each bank.

Ports:
- Clock  input  1  sole clock; all logic on rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- Enable  input  1  command qualifier.
- Read  input  1  read request when Enable=1.
- Write  input  1  write request when Enable=1.
- Address  input  ADDR_WIDTH  word address; bank = Address[ADDR_WIDTH-1 -: BANK_BITS].
- WriteData  input  DATA_WIDTH  write data.
- Refresh  input  1  on-demand refresh request pulse.
- Ready  output  1  controller can accept a command this cycle.
- ReadData  output  DATA_WIDTH  read result.
- ReadValid  output  1  ReadData valid, one-cycle pulse per read.
- RefreshBusy  output  1  refresh sweep in progress.
- RefreshBank  output  BANK_BITS  bank currently being refreshed.
- Error  output  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (ResetN=0, asynchronous): state=IDLE; Ready=0; ReadData=0; ReadValid=0; RefreshBusy=0; RefreshBank=0; Error=0; interval counter=0; pending flag=0; read pipeline cleared. Array contents are not reset.
- Ready is registered. It is 1 in IDLE with no pending refresh. It first rises the cycle after ResetN deasserts.
- Command acceptance: Enable & Ready & (Read ^ Write).
  - Write: array[Address] <= WriteData at that edge.
  - Read: array sampled at the accept edge. ReadData/ReadValid appear READ_LATENCY cycles later. One read can be accepted per cycle (fully pipelined).
- Enable & Read & Write: no array access; Error=1 the next cycle for one cycle, even when Ready=0.
- Enable=0: Read/Write ignored. A command issued while Ready=0 is dropped silently, with no Error.
- Write-then-read, same address, back-to-back cycles: the read returns the new data.
- Interval counter:
  - Increments every cycle outside REFRESH.
  - Reaching REFRESH_INTERVAL-1, or Refresh=1 in any cycle outside REFRESH, sets pending. Refresh=1 during REFRESH is ignored.
  - Pending forces Ready=0 from the next edge.
- FSM transitions:
  - IDLE -> DRAIN when pending.
  - DRAIN holds until all in-flight reads have issued ReadValid, then -> REFRESH.
  - REFRESH: RefreshBusy=1. RefreshBank steps 0..NUM_BANKS-1, REFRESH_CYCLES cycles per bank. After the last bank -> IDLE.
  - On REFRESH exit: RefreshBusy=0, RefreshBank=0, interval counter=0, pending=0, Ready=1.
- Total REFRESH duration: REFRESH_CYCLES*NUM_BANKS cycles (16 at defaults). Array contents are preserved across refresh.
- ResetN asserted mid-read or mid-refresh: the pipeline is flushed immediately, with no ReadValid for lost reads, and the FSM returns to IDLE.
- Address wrap-around is not applicable: every Address value is a valid location.

Test Plan:
- Reset release: ResetN 0->1 -> Ready=1 at the next edge; all other outputs 0; interval counter restarts at 0.
- Write 0x1A5 @ addr 0x003, then read 0x003 next cycle -> ReadValid with ReadData=0x1A5 exactly 2 cycles after the read accept.
- Four back-to-back reads of addresses 0x000, 0x100, 0x200, 0x300 (one per bank, preloaded 0x011/0x022/0x033/0x044) -> four consecutive ReadValid pulses carrying the data in order.
- Automatic refresh: idle for 63 cycles -> Ready falls; RefreshBusy=1 for 16 cycles with RefreshBank 0,0,0,0,1,...,3; then Ready=1; a subsequent read returns the pre-refresh data.
- Refresh pulse issued the cycle after two reads are accepted -> both ReadValid pulses arrive before RefreshBusy rises; a write attempted while Ready=0 leaves the memory unchanged.
- Enable=1, Read=1, Write=1 @ addr 0x005 -> Error pulses for one cycle, memory unchanged, no ReadValid; ResetN pulsed during REFRESH -> RefreshBusy=0 immediately.

Source files
------------

// File: rtl/sdr_qsram_ctrl.sv
// Quad-bank SRAM: READ_LATENCY-cycle pipelined reads, refresh sweep across all banks.
// Ready drops while a refresh is pending or running; commands issued while Ready=0 are dropped.
module sdr_qsram_ctrl #(
    parameter int ADDR_WIDTH       = 10,
    parameter int DATA_WIDTH       = 9,
    parameter int BANK_BITS        = 2,
    parameter int READ_LATENCY     = 2,
    parameter int REFRESH_INTERVAL = 64,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  Enable,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  Refresh,
    output logic                  Ready,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  RefreshBusy,
    output logic [BANK_BITS-1:0]  RefreshBank,
    output logic                  Error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = $clog2(REFRESH_INTERVAL) + 1;
    localparam int CYC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_TRIP  = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [CYC_W-1:0]     CYC_LAST  = CYC_W'(REFRESH_CYCLES - 1);
    localparam logic [BANK_BITS-1:0] BANK_LAST = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        REFRESH = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0]   mem    [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_dat [READ_LATENCY];
    logic [READ_LATENCY-1:0] rd_vld;

    state_t                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CYC_W-1:0]        cyc_q;
    logic [BANK_BITS-1:0]    bank_q;
    logic                    ready_d;
    logic                    rd_acc, wr_acc, in_flight, sweep_done;

    assign rd_acc     = Enable & Ready & Read & ~Write;
    assign wr_acc     = Enable & Ready & Write & ~Read;
    assign in_flight  = |rd_vld;
    assign sweep_done = (state_q == REFRESH) && (bank_q == BANK_LAST) && (cyc_q == CYC_LAST);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending_q)  state_d = DRAIN;
            DRAIN:   if (!in_flight) state_d = REFRESH;
            REFRESH: if (sweep_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        RefreshBusy = (state_q == REFRESH);
        ready_d     = (state_d == IDLE) && !pending_d;
    end

    // Interval counter and pending flag freeze during the sweep and clear as it ends.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (sweep_done) begin
            pending_d = 1'b0;
            cnt_d     = '0;
        end else if (state_q != REFRESH) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (Refresh || (cnt_q == CNT_TRIP)) begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Ready     <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            Error     <= 1'b0;
        end else begin
            Ready     <= ready_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            Error     <= Enable & Read & Write;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cyc_q  <= '0;
            bank_q <= '0;
        end else if (state_q == REFRESH) begin
            if (cyc_q == CYC_LAST) begin
                cyc_q  <= '0;
                bank_q <= (bank_q == BANK_LAST) ? '0 : bank_q + BANK_BITS'(1);
            end else begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
        end else begin
            cyc_q  <= '0;
            bank_q <= '0;
        end
    end

    assign RefreshBank = bank_q;

    always_ff @(posedge Clock) begin
        if (wr_acc) begin
            mem[Address] <= WriteData;
        end
        rd_dat[0] <= mem[Address];
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_dat[i] <= rd_dat[i-1];
        end
    end

    // Valid bits carry reset so a reset drops every in-flight read.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rd_vld    <= '0;
            ReadValid <= 1'b0;
            ReadData  <= '0;
        end else begin
            rd_vld[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
            end
            ReadValid <= rd_vld[READ_LATENCY-1];
            if (rd_vld[READ_LATENCY-1]) begin
                ReadData <= rd_dat[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_sdr_qsram_ctrl.sv
// Directed bench for sdr_qsram_ctrl with a read-data scoreboard.
module tb_sdr_qsram_ctrl;

    localparam int RL = 2;
    localparam int RC = 4;

    logic       Clock, ResetN, Enable, Read, Write, Refresh;
    logic [9:0] Address;
    logic [8:0] WriteData, ReadData;
    logic       Ready, ReadValid, RefreshBusy, Error;
    logic [1:0] RefreshBank;

    sdr_qsram_ctrl #(
        .ADDR_WIDTH(10), .DATA_WIDTH(9), .BANK_BITS(2),
        .READ_LATENCY(RL), .REFRESH_INTERVAL(64), .REFRESH_CYCLES(RC)
    ) dut (
        .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Read(Read), .Write(Write),
        .Address(Address), .WriteData(WriteData), .Refresh(Refresh), .Ready(Ready),
        .ReadData(ReadData), .ReadValid(ReadValid), .RefreshBusy(RefreshBusy),
        .RefreshBank(RefreshBank), .Error(Error)
    );

    typedef struct {
        logic [8:0] dat;
        int         due;
    } exp_t;

    exp_t       sb_q [$];
    logic [8:0] model [0:1023];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rel_cyc, rise, fall, last_due;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_write(input logic [9:0] a, input logic [8:0] d, input bit acc);
        Enable = 1'b1; Write = 1'b1; Read = 1'b0; Address = a; WriteData = d;
        tick();
        Enable = 1'b0; Write = 1'b0;
        if (acc) model[a] = d;
    endtask

    task automatic do_read(input logic [9:0] a);
        exp_t e;
        e.dat = model[a];
        e.due = cyc + 1 + RL;
        sb_q.push_back(e);
        Enable = 1'b1; Read = 1'b1; Write = 1'b0; Address = a;
        tick();
        Enable = 1'b0; Read = 1'b0;
    endtask

    task automatic wait_busy(input logic val, output int at);
        int n = 0;
        while (RefreshBusy !== val && n < 40) begin
            tick();
            n++;
        end
        chk("busy_wait", 32'(RefreshBusy), 32'(val));
        at = cyc;
    endtask

    // Scoreboard: every cycle either the head entry is due or ReadValid must be low.
    always @(posedge Clock) begin
        #1;
        while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            chk("rd_missed", 32'(cyc), 32'(sb_q[0].due));
            void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            chk("rd_valid", 32'(ReadValid), 32'd1);
            chk("rd_data", 32'(ReadData), 32'(sb_q[0].dat));
            void'(sb_q.pop_front());
        end else begin
            chk("rd_spurious", 32'(ReadValid), 32'd0);
        end
    end

    initial begin
        ResetN = 1'b0; Enable = 1'b0; Read = 1'b0; Write = 1'b0;
        Address = '0; WriteData = '0; Refresh = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_ready", 32'(Ready), 32'd0);
        chk("rst_rdata", 32'(ReadData), 32'd0);
        chk("rst_busy", 32'(RefreshBusy), 32'd0);
        chk("rst_bank", 32'(RefreshBank), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);

        ResetN  = 1'b1;
        rel_cyc = cyc;
        tick();
        chk("ready_rise", 32'(Ready), 32'd1);
        chk("busy_idle", 32'(RefreshBusy), 32'd0);
        chk("error_idle", 32'(Error), 32'd0);

        do_write(10'h003, 9'h1A5, 1'b1);
        do_read(10'h003);
        do_write(10'h000, 9'h011, 1'b1);
        do_write(10'h100, 9'h022, 1'b1);
        do_write(10'h200, 9'h033, 1'b1);
        do_write(10'h300, 9'h044, 1'b1);
        do_read(10'h000);
        do_read(10'h100);
        do_read(10'h200);
        do_read(10'h300);
        idle(4);

        do_write(10'h005, 9'h055, 1'b1);
        Enable = 1'b1; Read = 1'b1; Write = 1'b1; Address = 10'h005; WriteData = 9'h0AA;
        tick();
        Enable = 1'b0; Read = 1'b0; Write = 1'b0;
        chk("err_pulse", 32'(Error), 32'd1);
        tick();
        chk("err_clear", 32'(Error), 32'd0);
        do_read(10'h005);
        idle(4);

        while ((cyc - rel_cyc) < 63) tick();
        chk("ready_before_auto", 32'(Ready), 32'd1);
        tick();
        chk("ready_fall_auto", 32'(Ready), 32'd0);
        tick();
        chk("busy_drain", 32'(RefreshBusy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("busy_sweep", 32'(RefreshBusy), 32'd1);
            chk("refresh_bank", 32'(RefreshBank), 32'(i / RC));
        end
        tick();
        chk("busy_end", 32'(RefreshBusy), 32'd0);
        chk("ready_end", 32'(Ready), 32'd1);
        chk("bank_end", 32'(RefreshBank), 32'd0);
        do_read(10'h003);
        do_read(10'h200);
        idle(4);

        do_read(10'h100);
        do_read(10'h300);
        last_due = sb_q[$].due;
        Refresh = 1'b1;
        tick();
        Refresh = 1'b0;
        chk("ready_fall_req", 32'(Ready), 32'd0);
        do_write(10'h100, 9'h1FF, 1'b0);
        wait_busy(1'b1, rise);
        chk("busy_after_reads", 32'(rise > last_due), 32'd1);
        wait_busy(1'b0, fall);
        chk("refresh_len", 32'(fall - rise), 32'd16);
        chk("ready_after_req", 32'(Ready), 32'd1);
        do_read(10'h100);
        idle(4);

        do_read(10'h003);
        ResetN = 1'b0;
        sb_q.delete();
        #1;
        chk("rst_mid_read_ready", 32'(Ready), 32'd0);
        idle(3);
        ResetN = 1'b1;
        tick();
        chk("ready_rerelease", 32'(Ready), 32'd1);

        Refresh = 1'b1;
        tick();
        Refresh = 1'b0;
        wait_busy(1'b1, rise);
        idle(2);
        ResetN = 1'b0;
        #1;
        chk("rst_mid_ref_busy", 32'(RefreshBusy), 32'd0);
        chk("rst_mid_ref_bank", 32'(RefreshBank), 32'd0);
        chk("rst_mid_ref_ready", 32'(Ready), 32'd0);
        tick();
        ResetN = 1'b1;
        tick();
        chk("ready_after_ref_rst", 32'(Ready), 32'd1);
        chk("busy_after_ref_rst", 32'(RefreshBusy), 32'd0);
        do_read(10'h003);
        do_read(10'h005);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
